stim_check_engine: RTL
======================

Name: stim_check_engine

Overview:
- Synthesizable, parametrised stimulus-and-check engine. Drives N_IN-bit input vectors into a device under test (DUT) and compares the DUT response against a reference-model response, accounting for DUT pipeline latency.
- Generalises the fixed 2-input gate bench flow in four ways: any input/output width, exhaustive or LFSR-random modes, a start/busy/done handshake, and mismatch accounting.
- Sits beside a DUT inside generated test harnesses, on-chip or in simulation.

Parameters:
- N_IN, 2, DUT input width (2..32).
- N_OUT, 1, DUT output width (1..64).
- DUT_LAT, 0, DUT latency in clk cycles from stim to resp (0..15).
- CNT_W, 16, width of the vector count and index.
- ERR_W, 16, width of the mismatch counter.
- LFSR_SEED, 1, LFSR start value; 0 is replaced by 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a run; sampled in IDLE only.
- mode  in  1  0 = exhaustive, 1 = LFSR random; latched on start.
- num_vec  in  CNT_W  vector count in LFSR mode; latched on start; 0 is treated as 1.
- stim  out  N_IN  vector driven to DUT and reference model.
- stim_valid  out  1  stim is a live vector this cycle.
- dut_resp  in  N_OUT  DUT output.
- ref_resp  in  N_OUT  reference-model output, same latency as the DUT.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next accepted start.
- pass  out  1  valid while done; 1 when err_count is 0.
- err_count  out  ERR_W  mismatch count, saturating.
- first_fail_idx  out  CNT_W  index of the first mismatching vector.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE.
  - stim=0, stim_valid=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0.
  - Delay pipeline cleared.
  - A reset mid-run aborts the run; no partial result is kept.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE -> RUN on start=1: latch mode and num_vec; clear err_count, first_fail_idx, done, pass; busy=1 the next cycle.
  - start is ignored in RUN and DRAIN.
- RUN: one vector per cycle, stim_valid=1. Vector index k runs 0,1,2,...
  - Exhaustive mode: stim=k. Total vectors = 2^N_IN; index wraps at the top only to terminate.
  - LFSR mode: maximal-length Galois LFSR of width N_IN, seeded with LFSR_SEED. Issues num_vec vectors and never emits 0.
  - After the last vector: go to DRAIN if DUT_LAT>0, otherwise DONE.
- DRAIN: stim_valid=0, stim holds its last value. Lasts exactly DUT_LAT cycles, then DONE.
- Compare alignment: stim_valid and index k travel through a DUT_LAT-deep delay line.
  - At a clk edge where the delayed valid is 1, compare dut_resp with ref_resp.
  - DUT_LAT=0 compares the same cycle stim is presented (combinational DUT).
- On mismatch: err_count increments, saturating at all-ones. If this is the first mismatch, first_fail_idx = delayed k.
- DONE: busy=0, done=1, pass = (err_count==0). Outputs hold until start or rst.
- Latency: in exhaustive mode with DUT_LAT=L, done rises 1 + 2^N_IN + L cycles after the start edge.

Optional Feature:
- Macro: STIM_CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves RUN or DRAIN to DONE on the next cycle.
  - stim_valid drops and vectors in flight are discarded.
  - err_count is 1 and pass=0.
- Undefined: every vector runs to completion.

Decomposition:
- Package stim_check_pkg holds:
  - FSM state enum.
  - Mode constants MODE_EXH and MODE_LFSR.
  - LFSR tap-mask constant table for widths 2..32.
- One sub-module, stim_lfsr: parametrised width and seed, with enable, load and state output.

Test Plan:
- Exhaustive, N_IN=2, N_OUT=1, NAND DUT equal to NAND reference, DUT_LAT=0 -> stim sequence 0,1,2,3 with stim_valid high for 4 cycles; done after 5 cycles; pass=1; err_count=0.
- Same setup, DUT output forced wrong for stim=2 -> err_count=1, first_fail_idx=2, pass=0.
- DUT_LAT=2, registered 2-stage DUT equal to reference, N_IN=4 -> 16 vectors, 2 DRAIN cycles, done 19 cycles after start, pass=1.
- LFSR mode, N_IN=4, num_vec=10 -> exactly 10 stim_valid cycles; no vector equals 0; no repeats; the second run with the same seed gives an identical sequence.
- ERR_W=2, DUT output always inverted, exhaustive N_IN=3 -> err_count saturates at 3; first_fail_idx=0.
- rst asserted at RUN index 5, then start asserted while busy in a new run -> immediate IDLE with all outputs 0; the in-busy start is ignored; the run completes normally.

Source files
------------

// File: rtl/stim_check_pkg.sv
// stim_check_pkg
// Shared types and constants for the stimulus-and-check engine:
//   - state_e      : engine FSM states (IDLE, RUN, DRAIN, DONE)
//   - MODE_EXH     : exhaustive counting stimulus
//   - MODE_LFSR    : pseudo-random stimulus from a maximal-length LFSR
//   - lfsr_taps()  : Galois tap mask for LFSR widths 2..32
package stim_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_EXH  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Right-shifting Galois form: bit (t-1) is set for every polynomial tap t.
    // Every entry is a primitive polynomial, so the period is 2^w - 1 and the
    // all-zero state is never reached from a non-zero seed.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] m;
        case (width)
            2:       m = 32'h0000_0003;
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0003;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stim_lfsr.sv
// stim_lfsr
// Maximal-length Galois LFSR used as the random stimulus source.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (returns to seed)
//   en       : advance one step
//   load     : reload the seed (takes priority over en)
//   state    : current LFSR value, never zero
module stim_lfsr
    import stim_check_pkg::*;
#(
    parameter int          WIDTH = 2,
    parameter logic [31:0] SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_T = SEED[WIDTH-1:0];
    // A zero seed would lock the register at zero forever.
    localparam logic [WIDTH-1:0] SEED_W = (SEED_T == '0) ? WIDTH'(1) : SEED_T;

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED_W;
        end else if (en) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_W;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/stim_check_engine.sv
// stim_check_engine
// Drives N_IN-bit vectors into a DUT and a reference model, compares their
// responses DUT_LAT cycles later and accumulates a saturating mismatch count.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, mode, num_vec: run request; mode/num_vec latched with start
//   stim, stim_valid    : vector to DUT and reference model
//   dut_resp, ref_resp  : responses, both DUT_LAT cycles behind stim
//   busy, done, pass    : run status
//   err_count           : saturating mismatch count
//   first_fail_idx      : vector index of the first mismatch
// Optional build macro: STIM_CHECK_STOP_ON_FAIL_EN -- when defined, the first
// mismatch ends the run on the next cycle and discards vectors in flight.
//
// Handshake: start is a request accepted only in IDLE or DONE (never while
// busy); busy is high from the cycle after acceptance until the run ends;
// done (with pass) then stays high until the next accepted start or reset.
module stim_check_engine
    import stim_check_pkg::*;
#(
    parameter int          N_IN      = 2,
    parameter int          N_OUT     = 1,
    parameter int          DUT_LAT   = 0,
    parameter int          CNT_W     = 16,
    parameter int          ERR_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_vec,
    output logic [N_IN-1:0]  stim,
    output logic             stim_valid,
    input  logic [N_OUT-1:0] dut_resp,
    input  logic [N_OUT-1:0] ref_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] nvec_q, nvec_d;
    logic [CNT_W-1:0] k_q, k_d;             // index of the next vector to issue
    logic [CNT_W-1:0] cur_idx_q, cur_idx_d; // index of the vector on stim
    logic [N_IN-1:0]  exh_q, exh_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic             stim_valid_q, stim_valid_d;
    logic             all_sent_q, all_sent_d;
    logic [3:0]       drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;

    logic             lfsr_en, lfsr_load;
    logic [N_IN-1:0]  lfsr_state;
    logic             is_last;
    logic             cmp_valid;
    logic [CNT_W-1:0] cmp_idx;
    logic             mismatch;

    stim_lfsr #(
        .WIDTH (N_IN),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (lfsr_en),
        .load  (lfsr_load),
        .state (lfsr_state)
    );

    // Exhaustive runs end on the all-ones vector, so the index width never
    // limits the run length.
    assign is_last = (mode_q == MODE_LFSR) ? (k_q == nvec_q - CNT_W'(1))
                                           : (exh_q == '1);

    // Valid and index follow the DUT pipeline so each response is paired with
    // the vector that produced it.
    if (DUT_LAT == 0) begin : g_nodly
        assign cmp_valid = stim_valid_q;
        assign cmp_idx   = cur_idx_q;
    end else begin : g_dly
        logic [DUT_LAT-1:0] dv_q, dv_d;
        logic [CNT_W-1:0]   di_q [DUT_LAT];
        logic [CNT_W-1:0]   di_d [DUT_LAT];

        always_comb begin
            dv_d    = dv_q;
            di_d    = di_q;
            dv_d[0] = stim_valid_q;
            di_d[0] = cur_idx_q;
            for (int i = 1; i < DUT_LAT; i++) begin
                dv_d[i] = dv_q[i-1];
                di_d[i] = di_q[i-1];
            end
            // Outside a run the line is emptied, which also discards vectors
            // left in flight by an early stop.
            if (!(state_q == ST_RUN || state_q == ST_DRAIN)) begin
                dv_d = '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dv_q <= '0;
                di_q <= '{default: '0};
            end else begin
                dv_q <= dv_d;
                di_q <= di_d;
            end
        end

        assign cmp_valid = dv_q[DUT_LAT-1];
        assign cmp_idx   = di_q[DUT_LAT-1];
    end

    assign mismatch = cmp_valid && (state_q == ST_RUN || state_q == ST_DRAIN)
                      && (dut_resp != ref_resp);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        nvec_d       = nvec_q;
        k_d          = k_q;
        cur_idx_d    = cur_idx_q;
        exh_d        = exh_q;
        stim_d       = stim_q;
        stim_valid_d = stim_valid_q;
        all_sent_d   = all_sent_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        first_d      = first_q;
        lfsr_en      = 1'b0;
        lfsr_load    = 1'b0;

        if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
                first_d = cmp_idx;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    mode_d     = mode;
                    nvec_d     = (num_vec == '0) ? CNT_W'(1) : num_vec;
                    k_d        = '0;
                    exh_d      = '0;
                    all_sent_d = 1'b0;
                    err_d      = '0;
                    first_d    = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    lfsr_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!all_sent_q) begin
                    stim_d       = (mode_q == MODE_LFSR) ? lfsr_state : exh_q;
                    stim_valid_d = 1'b1;
                    cur_idx_d    = k_q;
                    k_d          = k_q + CNT_W'(1);
                    exh_d        = exh_q + N_IN'(1);
                    lfsr_en      = (mode_q == MODE_LFSR);
                    all_sent_d   = is_last;
                end else begin
                    stim_valid_d = 1'b0;
                    if (DUT_LAT > 0) begin
                        state_d = ST_DRAIN;
                        drain_d = 4'(DUT_LAT - 1);
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef STIM_CHECK_STOP_ON_FAIL_EN
        if (mismatch && err_q == '0) begin
            state_d      = ST_DONE;
            stim_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            pass_d       = 1'b0;
            lfsr_en      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_EXH;
            nvec_q       <= '0;
            k_q          <= '0;
            cur_idx_q    <= '0;
            exh_q        <= '0;
            stim_q       <= '0;
            stim_valid_q <= 1'b0;
            all_sent_q   <= 1'b0;
            drain_q      <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_q      <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            nvec_q       <= nvec_d;
            k_q          <= k_d;
            cur_idx_q    <= cur_idx_d;
            exh_q        <= exh_d;
            stim_q       <= stim_d;
            stim_valid_q <= stim_valid_d;
            all_sent_q   <= all_sent_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            first_q      <= first_d;
        end
    end

    assign stim           = stim_q;
    assign stim_valid     = stim_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = first_q;

endmodule
